// File: rtl/usb4_clk_pkg.sv
// Shared constants and types for the USB4 clock-enable generator.
// Increments assume ACC_W=32 and an 80 GHz local clock, rounded to nearest.
package usb4_clk_pkg;

  localparam logic [31:0] INC_GEN2_LANE = 32'h2000_0000;
  localparam logic [31:0] INC_GEN3_LANE = 32'h4000_0000;
  localparam logic [31:0] INC_GEN4      = 32'h8000_0000;
  localparam logic [31:0] INC_GEN2_FSM  = 32'd520603723;
  localparam logic [31:0] INC_GEN3_FSM  = 32'd1041207447;
  localparam logic [31:0] INC_SB        = 32'd53687;

  typedef enum logic {
    SEQ_HOLD,
    SEQ_RELEASE
  } seq_state_e;

  // A single channel still needs a 1-bit select port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_nco.sv
// One tick channel: phase accumulator with a shadowed increment that is
// swapped in only on a tick boundary, while idle, or while disabled.
module clk_en_nco #(
  parameter int ACC_W = 32
) (
  input  logic             local_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             align,
  input  logic             we,
  input  logic [ACC_W-1:0] wdata,
  output logic             tick,
  output logic             pend
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             apply;

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, inc};
    carry = sum[ACC_W];
    // Align edges leave the pending update for a later boundary.
    apply = pend && !align && (carry || (inc == '0) || !en);
  end

  // NOTE: every register, shadow included, is cleared by rst; a stale shadow
  // surviving reset would otherwise be applied on the first idle edge.
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      inc    <= '0;
      shadow <= '0;
      pend   <= 1'b0;
      tick   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates mean the apply test and the sum both see
      // the pre-edge inc, so the boundary tick is issued at the old rate.
      if (align) begin
        acc  <= '0;
        tick <= 1'b0;
      end else if (en) begin
        acc  <= sum[ACC_W-1:0];
        tick <= carry;
      end else begin
        tick <= 1'b0;
      end

      // A fresh write supersedes any unapplied value and restarts the wait.
      if (we) begin
        shadow <= wdata;
        pend   <= 1'b1;
      end else if (apply) begin
        inc  <= shadow;
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lane_clk_en_gen.sv
// Multi-channel NCO clock-enable generator with config decode, align fan-out
// and a reset sequencer that releases after HOLD_TICKS sideband ticks.
module lane_clk_en_gen
  import usb4_clk_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = 32,
  parameter int SB_CH      = 0,
  parameter int HOLD_TICKS = 3
) (
  input  logic                      local_clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]          cfg_inc,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      align,
  output logic [NUM_CH-1:0]         tick_o,
  output logic [NUM_CH-1:0]         pending_o,
  output logic                      sync_rst_o
);

  localparam int CH_W   = ch_w(NUM_CH);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  logic [NUM_CH-1:0] we_vec;
  seq_state_e        state;
  logic [HOLD_W-1:0] hold_cnt;

  // NOTE: default assignment first so the decoder can never infer a latch.
  // Selects at or above NUM_CH match no channel and are dropped.
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) we_vec[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_nco #(
      .ACC_W (ACC_W)
    ) u_nco (
      .local_clk (local_clk),
      .rst       (rst),
      .en        (ch_en[g]),
      .align     (align),
      .we        (we_vec[g]),
      .wdata     (cfg_inc),
      .tick      (tick_o[g]),
      .pend      (pending_o[g])
    );
  end

  // Counts registered sideband ticks, so release lands one edge after the last.
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      state      <= SEQ_HOLD;
      hold_cnt   <= '0;
      sync_rst_o <= 1'b1;
    end else begin
      case (state)
        SEQ_HOLD: begin
          if (tick_o[SB_CH]) begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= SEQ_RELEASE;
              sync_rst_o <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        SEQ_RELEASE: sync_rst_o <= 1'b0;
        default: begin
          state      <= SEQ_HOLD;
          sync_rst_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_clk_en_gen.sv
// Directed bench for lane_clk_en_gen; edge numbers count rising edges after
// each rst release, inputs are driven 1 time unit after the previous edge.
module tb_lane_clk_en_gen;
  import usb4_clk_pkg::*;

  localparam int NUM_CH     = 3;
  localparam int ACC_W      = 32;
  localparam int SB_CH      = 0;
  localparam int HOLD_TICKS = 3;

  logic              local_clk = 1'b0;
  logic              rst       = 1'b1;
  logic              cfg_we    = 1'b0;
  logic [1:0]        cfg_ch    = '0;
  logic [ACC_W-1:0]  cfg_inc   = '0;
  logic [NUM_CH-1:0] ch_en     = '0;
  logic              align     = 1'b0;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] pending_o;
  logic              sync_rst_o;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  lane_clk_en_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .SB_CH      (SB_CH),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .local_clk  (local_clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_inc    (cfg_inc),
    .ch_en      (ch_en),
    .align      (align),
    .tick_o     (tick_o),
    .pending_o  (pending_o),
    .sync_rst_o (sync_rst_o)
  );

  always #5 local_clk = ~local_clk;

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge local_clk);
    edge_n++;
    #1;
  endtask

  initial begin
    repeat (3) @(posedge local_clk);
    #1;
    check("rst_tick", 32'(tick_o), 32'd0);
    check("rst_pend", 32'(pending_o), 32'd0);
    check("rst_sync", 32'(sync_rst_o), 32'd1);

    // Part 1: ch0 at 2^31 written at edge 1, applied edge 2 (inc was 0),
    // acc reaches 2^31 at edge 3 and wraps at edges 4,6,8,... The third tick
    // (edge 8) is seen by the sequencer at edge 9. Ch1 gets a write at edge 10.
    rst    = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 10; e++) begin
      cfg_we  = (e == 1) || (e == 10);
      cfg_ch  = (e == 10) ? 2'd1 : 2'd0;
      cfg_inc = INC_GEN4;
      ch_en   = 3'b001;
      step();
      cfg_we = 1'b0;
      check("p1_tick0", 32'(tick_o[0]), 32'(e >= 4 && e % 2 == 0));
      check("p1_sync", 32'(sync_rst_o), 32'(e <= 8));
      if (e <= 2) check("p1_pend0", 32'(pending_o[0]), 32'(e == 1));
    end
    check("p1_pend_ch1", 32'(pending_o), 32'b010);

    // Asynchronous reset mid-period clears outputs without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_sync", 32'(sync_rst_o), 32'd1);
    check("arst_tick", 32'(tick_o), 32'd0);
    check("arst_pend", 32'(pending_o), 32'd0);
    step();

    // Part 2a: ch0 at 2^30, applied edge 2, ticks at 6,10,14; release at 15.
    rst    = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 16; e++) begin
      cfg_we  = (e == 1);
      cfg_ch  = 2'd0;
      cfg_inc = INC_GEN3_LANE;
      ch_en   = 3'b001;
      step();
      cfg_we = 1'b0;
      check("p2_tick0", 32'(tick_o[0]), 32'(e >= 6 && (e - 6) % 4 == 0));
      check("p2_sync", 32'(sync_rst_o), 32'(e < 15));
    end

    // Part 2b: ch1 at 2^29 (applied 18, ticks 26,34); 2^30 written at 28 stays
    // pending until the tick at 34, then ticks at 38,42,46.
    for (int e = 17; e <= 46; e++) begin
      cfg_we  = (e == 17) || (e == 28);
      cfg_ch  = 2'd1;
      cfg_inc = (e == 17) ? INC_GEN2_LANE : INC_GEN3_LANE;
      ch_en   = 3'b011;
      step();
      cfg_we = 1'b0;
      check("p2b_pend1", 32'(pending_o[1]), 32'(e == 17 || (e >= 28 && e < 34)));
      if (e >= 19)
        check("p2b_tick1", 32'(tick_o[1]), 32'(e == 26 || e == 34 || e == 38 || e == 42 || e == 46));
    end
    check("p2b_sync", 32'(sync_rst_o), 32'd0);

    // Part 2c: ch2 at 2^29 from edge 49. Align at 54 (where ch0/ch1 would
    // tick) zeroes all phases; a ch2 write in the same cycle is still taken.
    for (int e = 47; e <= 62; e++) begin
      cfg_we  = (e == 47) || (e == 54);
      cfg_ch  = 2'd2;
      cfg_inc = (e == 47) ? INC_GEN2_LANE : INC_GEN3_LANE;
      ch_en   = 3'b111;
      align   = (e == 54);
      step();
      cfg_we = 1'b0;
      align  = 1'b0;
      check("p2c_pend", 32'(pending_o), (e == 47 || (e >= 54 && e < 62)) ? 32'b100 : 32'b000);
      if (e >= 54)
        check("p2c_tick", 32'(tick_o), (e == 58) ? 32'b011 : (e == 62) ? 32'b111 : 32'b000);
    end

    // Part 2d: ch1 acc is 2^31 after edge 64; a 2^29 write at 64 is applied
    // while disabled (65..69) and the frozen phase wraps at 73, then 81.
    for (int e = 63; e <= 81; e++) begin
      cfg_we  = (e == 64);
      cfg_ch  = 2'd1;
      cfg_inc = INC_GEN2_LANE;
      ch_en   = (e >= 65 && e <= 69) ? 3'b101 : 3'b111;
      step();
      cfg_we = 1'b0;
      check("p2d_pend1", 32'(pending_o[1]), 32'(e == 64));
      check("p2d_tick1", 32'(tick_o[1]), 32'(e == 73 || e == 81));
    end

    // Part 3: fresh reset, out-of-range write, all increments stay 0.
    rst = 1'b1;
    step();
    rst    = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 1000; e++) begin
      cfg_we  = (e == 1);
      cfg_ch  = 2'd3;
      cfg_inc = INC_GEN4;
      ch_en   = 3'b111;
      step();
      cfg_we = 1'b0;
      if (e == 1) check("p3_pend", 32'(pending_o), 32'd0);
      check("p3_tick", 32'(tick_o), 32'd0);
    end
    check("p3_sync", 32'(sync_rst_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
